pong_tick_sequencer: RTL

- Game-update scheduler for the Pong datapath.
- Contains a programmable tick divider on fastclk; each game tick runs one update frame.
- A frame is four fixed phases in strict order: PADDLE, BALL, COLLIDE, SCORE. Each phase uses a req/done handshake with its owning subsystem.
- Sits between the clock domain and the game-logic blocks, so only one subsystem updates game state at a time.

---
 rtl/pong_tick_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pong_tick_sequencer.sv
// Pong game-tick scheduler: programmable divider plus a PADDLE/BALL/COLLIDE/SCORE phase sequencer.
// Optional phase watchdog enabled by defining TICK_SEQ_WATCHDOG_EN.
module pong_tick_sequencer #(
    parameter int CNT_W          = 24,
    parameter int DEFAULT_PERIOD = 5000000,
    parameter int OVR_W          = 8
`ifdef TICK_SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES    = 1024
`endif
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             period_load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [3:0]       phase_done,
    output logic [3:0]       phase_req,
    output logic             tick,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [OVR_W-1:0] overrun_cnt
`ifdef TICK_SEQ_WATCHDOG_EN
    ,
    output logic             wdog_err,
    output logic [3:0]       wdog_phase
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PADDLE  = 3'd1;
    localparam logic [2:0] BALL    = 3'd2;
    localparam logic [2:0] COLLIDE = 3'd3;
    localparam logic [2:0] SCORE   = 3'd4;

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        if (p < CNT_W'(2))
            return CNT_W'(2);
        return p;
    endfunction

    function automatic logic [3:0] req_of(input logic [2:0] s);
        case (s)
            PADDLE:  return 4'b0001;
            BALL:    return 4'b0010;
            COLLIDE: return 4'b0100;
            SCORE:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_reg;
    logic             wrap;

    assign wrap = (count == period_reg - CNT_W'(1));

    // A load restarts the count and suppresses any wrap that would have landed on the same edge.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            period_reg <= DEF_PERIOD;
            tick       <= 1'b0;
        end else if (period_load) begin
            period_reg <= clamp_period(period_in);
            count      <= '0;
            tick       <= 1'b0;
        end else if (enable) begin
            count <= wrap ? '0 : count + CNT_W'(1);
            tick  <= wrap;
        end else begin
            tick  <= 1'b0;
        end
    end

    logic [2:0] state;
    logic [2:0] next_state;
    logic       done_hit;
    logic       advance;

    // phase_req mirrors the state, so masking with it ignores dones from inactive phases and in IDLE.
    assign done_hit = |(phase_req & phase_done);

`ifdef TICK_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt;
    logic            timeout;

    assign timeout = (state != IDLE) && !done_hit && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
    assign advance = done_hit || timeout;

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            wdog_cnt   <= '0;
            wdog_err   <= 1'b0;
            wdog_phase <= 4'b0000;
        end else begin
            wdog_cnt   <= (state == IDLE || next_state != state) ? '0 : wdog_cnt + WD_W'(1);
            wdog_err   <= timeout;
            wdog_phase <= wdog_phase | (timeout ? phase_req : 4'b0000);
        end
    end
`else
    assign advance = done_hit;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick)    next_state = PADDLE;
            PADDLE:  if (advance) next_state = BALL;
            BALL:    if (advance) next_state = COLLIDE;
            COLLIDE: if (advance) next_state = SCORE;
            SCORE:   if (advance) next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Ticks seen outside IDLE are dropped and counted, including the SCORE completion cycle.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase_req   <= 4'b0000;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state      <= next_state;
            phase_req  <= req_of(next_state);
            busy       <= (next_state != IDLE);
            frame_done <= (state == SCORE) && advance;
            overrun    <= tick && (state != IDLE);
            if (tick && (state != IDLE) && (overrun_cnt != {OVR_W{1'b1}}))
                overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
    end

endmodule
